uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1_000_000, serial bit rate in baud.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, >= 2.
REQ-004 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port serial_in  input  1  UART RX line; idle high; asynchronous to clk.
REQ-007 SHALL have port data_out  output  8  byte at the FIFO head (show-ahead).
REQ-008 SHALL have port data_out_valid  output  1  FIFO not empty.
REQ-009 SHALL have port data_out_ready  input  1  consumer pops the head when high together with data_out_valid.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-011 SHALL have port overrun  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-012 SHALL have port frame_err  output  1  sticky; a stop bit was sampled low.
REQ-013 SHALL have port clear_err  input  1  clears overrun and frame_err on the next edge.

Function
REQ-014 SHALL pass serial_in through a 2-flop synchronizer, reset value 1; the FSM uses only the synchronized value rx_s.
REQ-015 SHALL use bit period BIT = CLOCK_FREQ/BAUD_RATE cycles (integer division) and half period HALF = BIT/2.
REQ-016 SHALL implement the FSM states IDLE, START, DATA and STOP, with a cycle counter and a 3-bit bit index.
REQ-017 IDLE: SHALL go to START with counter = 0 when rx_s = 0.
REQ-018 START: SHALL sample rx_s at counter = HALF-1; if low, go to DATA with counter = 0; if high, return to IDLE (false start, no error flagged).
REQ-019 DATA: SHALL sample at counter = BIT-1, shifting bits in LSB-first; after the 8th sample, go to STOP with counter = 0.
REQ-020 STOP: SHALL sample at counter = BIT-1; if high, push the byte; if low, discard the byte and set frame_err; then go to IDLE in the same cycle.
REQ-021 The pushed byte SHALL appear on data_out with data_out_valid = 1 on the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 A pop SHALL occur when data_out_valid && data_out_ready; the head SHALL then advance on the next edge.
REQ-023 A push while full with no pop SHALL drop the new byte, set overrun, and leave the FIFO contents unchanged.
REQ-024 A push and a pop in the same cycle (including when full) SHALL both succeed, leave fifo_count unchanged, and not set overrun.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from fifo_count.
REQ-026 If clear_err and a new error occur in the same cycle, the new error SHALL win and the flag SHALL stay set.
REQ-027 Back-to-back frames (a start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-028 On rst_n low: FSM SHALL be IDLE, counters 0, FIFO empty, data_out = 8'h00, data_out_valid = 0, fifo_count = 0, overrun = 0, frame_err = 0, synchronizer = 1.
REQ-029 A reset asserted mid-frame SHALL abort the frame; after release, the receiver SHALL ignore line activity until rx_s is seen high in IDLE.

Configuration
REQ-030 Macro UART_RX_MAJORITY_EN: when defined, each START, DATA and STOP sample SHALL be the 2-of-3 majority of rx_s at counter-1, counter and counter+1 around the nominal sample point; the decision SHALL be taken at the nominal point +1, and all state transitions SHALL shift one cycle later accordingly. When undefined, each sample SHALL be the single rx_s value at the nominal point.

Verification
REQ-031 Defaults (BIT = 50); send 8'h78 -> data_out = 8'h78, data_out_valid rises 477+/-2 cycles after the serial_in falling edge, fifo_count = 1.
REQ-032 Send 8'h78, 8'h79, 8'h7a, 8'h0d back-to-back with data_out_ready = 0, then pop -> bytes read out in order, no flags set.
REQ-033 Send 5 bytes (8'h31..8'h35) with data_out_ready = 0 -> fifo_count = 4, 8'h35 dropped, overrun = 1; pulse clear_err -> overrun = 0.
REQ-034 Send 8'h3e with the stop bit driven low -> no push, frame_err = 1; the next good byte 8'h20 is received correctly.
REQ-035 Drive a 10-cycle low glitch on an idle line -> return to IDLE, nothing pushed, no flags; with UART_RX_MAJORITY_EN defined, a 1-cycle spike at a data mid-bit of 8'h55 does not corrupt the received byte.
REQ-036 Assert rst_n low during DATA of 8'hA5 -> all outputs at reset values; a subsequent 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with a show-ahead receive FIFO and sticky overrun/framing flags.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around its sample point.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 1_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clear_err
);

    localparam int unsigned BIT  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF = BIT / 2;
    localparam int unsigned CW   = $clog2(BIT + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The START decision moves one cycle later, so every later sample lands at nominal+1.
    localparam logic [CW-1:0] START_PT = CW'(HALF);
`else
    localparam logic [CW-1:0] START_PT = CW'(HALF - 1);
`endif
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [1:0]      sync;
    logic [1:0]      fill;
    logic            armed;
    logic            rx_s;
    logic            sample;
    logic            stop_hit;
    logic            push;
    logic            bad_stop;
    logic            pop;
    logic            full;
    logic            wr_en;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], serial_in};
        end
    end

    assign rx_s = sync[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        stop_hit = 1'b0;
        if (state == STOP && cnt == BIT_LAST) begin
            stop_hit = 1'b1;
        end
        push     = stop_hit & sample;
        bad_stop = stop_hit & ~sample;
        pop      = data_out_valid & data_out_ready;
        full     = (fifo_count == FULL_CNT);
        wr_en    = push & (~full | pop);
    end

    // fill marks when the synchronizer holds real line data, so a line held low
    // across reset release is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            fill    <= '0;
            armed   <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_s && fill[1]) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == START_PT) begin
                        cnt   <= '0;
                        state <= sample ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sample, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO that coincides with a pop overwrites the slot being read out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign data_out       = mem[rd_ptr];
    assign data_out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at default parameters (BIT = 50 cycles).
module tb_uart_rx_fifo;

    localparam int BIT = 50;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       frame_err;
    logic       clear_err;

    int n_cmp;
    int n_bad;
    int lat;

    uart_rx_fifo #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (1_000_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .frame_err     (frame_err),
        .clear_err     (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        serial_in = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            cycles(BIT);
        end
        serial_in = stop_ok;
        cycles(BIT);
        serial_in = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, data_out}, {24'h0, exp});
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        clear_err      = 1'b0;
        cycles(5);

        chk("rst_data",  {24'h0, data_out}, 32'h00);
        chk("rst_valid", {31'h0, data_out_valid}, 32'h0);
        chk("rst_count", {29'h0, fifo_count}, 32'h0);
        chk("rst_ovr",   {31'h0, overrun}, 32'h0);
        chk("rst_ferr",  {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        cycles(20);

        // single byte and latency from the start-bit falling edge
        fork
            send_byte(8'h78, 1'b1);
            begin
                lat = 0;
                while (!data_out_valid && lat < 600) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk("lat_window", {31'h0, (lat >= 475 && lat <= 479)}, 32'h1);
        chk("one_data",  {24'h0, data_out}, 32'h78);
        chk("one_count", {29'h0, fifo_count}, 32'h1);
        pop_chk("one_pop", 8'h78);
        chk("one_empty", {31'h0, data_out_valid}, 32'h0);
        cycles(10);

        // back-to-back frames, no consumer
        send_byte(8'h78, 1'b1);
        send_byte(8'h79, 1'b1);
        send_byte(8'h7a, 1'b1);
        send_byte(8'h0d, 1'b1);
        cycles(10);
        chk("b2b_count", {29'h0, fifo_count}, 32'h4);
        chk("b2b_ovr",   {31'h0, overrun}, 32'h0);
        chk("b2b_ferr",  {31'h0, frame_err}, 32'h0);
        pop_chk("b2b_0", 8'h78);
        pop_chk("b2b_1", 8'h79);
        pop_chk("b2b_2", 8'h7a);
        pop_chk("b2b_3", 8'h0d);
        chk("b2b_empty", {29'h0, fifo_count}, 32'h0);
        cycles(10);

        // overflow: fifth byte dropped
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h31 + 8'(i), 1'b1);
        end
        cycles(10);
        chk("ovf_count", {29'h0, fifo_count}, 32'h4);
        chk("ovf_flag",  {31'h0, overrun}, 32'h1);
        pop_chk("ovf_0", 8'h31);
        pop_chk("ovf_1", 8'h32);
        pop_chk("ovf_2", 8'h33);
        pop_chk("ovf_3", 8'h34);
        chk("ovf_empty", {29'h0, fifo_count}, 32'h0);
        chk("ovf_sticky", {31'h0, overrun}, 32'h1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovf_clear", {31'h0, overrun}, 32'h0);
        cycles(10);

        // short low glitch on an idle line is a false start
        serial_in = 1'b0;
        cycles(10);
        serial_in = 1'b1;
        cycles(100);
        chk("glitch_count", {29'h0, fifo_count}, 32'h0);
        chk("glitch_ovr",   {31'h0, overrun}, 32'h0);
        chk("glitch_ferr",  {31'h0, frame_err}, 32'h0);

`ifdef UART_RX_MAJORITY_EN
        // one-cycle spike near the middle of data bit 3 of 8'h55
        serial_in = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = (i % 2 == 0);
            if (i == 3) begin
                cycles(26);
                serial_in = 1'b1;
                cycles(1);
                serial_in = 1'b0;
                cycles(BIT - 27);
            end else begin
                cycles(BIT);
            end
        end
        serial_in = 1'b1;
        cycles(BIT + 10);
        chk("spike_count", {29'h0, fifo_count}, 32'h1);
        pop_chk("spike_data", 8'h55);
        cycles(10);
`endif

        // framing error, then a good byte
        send_byte(8'h3e, 1'b0);
        cycles(100);
        chk("ferr_count", {29'h0, fifo_count}, 32'h0);
        chk("ferr_flag",  {31'h0, frame_err}, 32'h1);
        send_byte(8'h20, 1'b1);
        cycles(10);
        chk("ferr_next_data",  {24'h0, data_out}, 32'h20);
        chk("ferr_next_count", {29'h0, fifo_count}, 32'h1);
        chk("ferr_sticky",     {31'h0, frame_err}, 32'h1);

        // reset mid-frame of 8'hA5 (bits LSB first 1,0,1,0,0,...), released while the line is low
        serial_in = 1'b0;
        cycles(BIT);
        serial_in = 1'b1; cycles(BIT);
        serial_in = 1'b0; cycles(BIT);
        serial_in = 1'b1; cycles(BIT);
        serial_in = 1'b0; cycles(BIT);
        cycles(10);
        rst_n = 1'b0;
        cycles(10);
        chk("mid_rst_data",  {24'h0, data_out}, 32'h00);
        chk("mid_rst_valid", {31'h0, data_out_valid}, 32'h0);
        chk("mid_rst_count", {29'h0, fifo_count}, 32'h0);
        chk("mid_rst_ovr",   {31'h0, overrun}, 32'h0);
        chk("mid_rst_ferr",  {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        cycles(30);
        serial_in = 1'b1;
        cycles(600);
        chk("post_rst_count", {29'h0, fifo_count}, 32'h0);
        chk("post_rst_ferr",  {31'h0, frame_err}, 32'h0);
        send_byte(8'h5a, 1'b1);
        cycles(10);
        chk("post_rst_data",  {24'h0, data_out}, 32'h5a);
        chk("post_rst_cnt1",  {29'h0, fifo_count}, 32'h1);
        pop_chk("post_rst_pop", 8'h5a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
